conv_sequencer: RTL and testbench

- Controller that sequences one full 1-D linear convolution of two N-sample signed signals through a single shared, externally instantiated multi-cycle Booth multiplier.
- Loads signal A, then signal B, from one input stream.
- Issues all N*N products over a req/ack multiplier interface and accumulates them into 2N-1 result registers.
- Streams the results out with valid/ready.
- Sits between the sample source and the result consumer; owns no arithmetic except the accumulate adder.

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_sequencer_if.sv | 50 +++++
 rtl/conv_acc_bank.sv | 50 +++++
 rtl/conv_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution sequencer slice:
//   - conv_state_t : sequencer FSM state encoding
//   - N_DEFAULT, DW_DEFAULT, RW_DEFAULT : default sample count / widths
//   - idx_width()  : width of the result index (covers 0 .. 2N-2)
//   - ctr_width()  : width of the i/j product counters (covers 0 .. N-1)
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int N_DEFAULT  = 8;
  localparam int DW_DEFAULT = 8;
  localparam int RW_DEFAULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_MUL    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } conv_state_t;

  // Result index width: must hold 2N-2.
  function automatic int idx_width(input int n);
    return $clog2(2 * n - 1);
  endfunction

  // Product counter width: must hold N-1 (at least one bit).
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_sequencer_if
// Bundles every handshake of the sequencer:
//   control : start (in), busy/done (out)
//   input   : in_valid/in_data (in), in_ready (out)
//   multiply: mul_req/mul_a/mul_b (out), mul_ack/mul_p (in)
//   output  : out_valid/out_data/out_idx/out_last (out), out_ready (in)
// master = sequencer side, slave = environment (source, multiplier, sink).
// -----------------------------------------------------------------------------
interface conv_sequencer_if
  import conv_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT,
  parameter int IW = idx_width(N_DEFAULT)
);

  logic                   start;
  logic                   busy;
  logic                   done;

  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW-1:0]   in_data;

  logic                   mul_req;
  logic signed [DW-1:0]   mul_a;
  logic signed [DW-1:0]   mul_b;
  logic                   mul_ack;
  logic signed [2*DW-1:0] mul_p;

  logic                   out_valid;
  logic                   out_ready;
  logic signed [RW-1:0]   out_data;
  logic [IW-1:0]          out_idx;
  logic                   out_last;

  modport master (
    input  start, in_valid, in_data, mul_ack, mul_p, out_ready,
    output busy, done, in_ready, mul_req, mul_a, mul_b,
           out_valid, out_data, out_idx, out_last
  );

  modport slave (
    output start, in_valid, in_data, mul_ack, mul_p, out_ready,
    input  busy, done, in_ready, mul_req, mul_a, mul_b,
           out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/conv_acc_bank.sv
// -----------------------------------------------------------------------------
// conv_acc_bank
// NACC signed accumulators of RW bits.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clears every accumulator (same priority as reset)
//   add_en_i   : acc[add_idx_i] += add_val_i (wraps modulo 2^RW)
//   rd_idx_i   : combinational read index, rd_data_o = acc[rd_idx_i]
// Out-of-range indices are ignored on write and read back as zero.
// -----------------------------------------------------------------------------
module conv_acc_bank
  import conv_pkg::*;
#(
  parameter int NACC = 2 * N_DEFAULT - 1,
  parameter int RW   = RW_DEFAULT,
  parameter int IW   = idx_width(N_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 add_en_i,
  input  logic [IW-1:0]        add_idx_i,
  input  logic signed [RW-1:0] add_val_i,
  input  logic [IW-1:0]        rd_idx_i,
  output logic signed [RW-1:0] rd_data_o
);

  logic signed [RW-1:0] acc_q [NACC];

  // Accumulator storage: clear, or indexed read-modify-write.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int e = 0; e < NACC; e++) begin
        acc_q[e] <= '0;
      end
    end else if (add_en_i && (int'(add_idx_i) < NACC)) begin
      acc_q[add_idx_i] <= acc_q[add_idx_i] + add_val_i;
    end
  end

  // Indexed read port.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_idx_i) < NACC) begin
      rd_data_o = acc_q[rd_idx_i];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
// Sequences one 1-D linear convolution of two N-sample signed signals through
// an external multi-cycle multiplier.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset, abandons any operation at once
//   bus  : conv_sequencer_if.master -- start/busy/done, sample input stream,
//          multiplier req/ack, result output stream (valid/ready).
// Flow: IDLE -> LOAD_A (N beats) -> LOAD_B (N beats) -> MUL (N*N products)
//       -> DRAIN (2N-1 results) -> DONE (one cycle) -> IDLE.
// All interface outputs are registered. Requires N >= 2.
// -----------------------------------------------------------------------------
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  conv_sequencer_if.master  bus
);

  localparam int IW   = idx_width(N);
  localparam int CW   = ctr_width(N);
  localparam int NACC = 2 * N - 1;

  localparam logic [IW-1:0] K_LOAD_LAST = IW'(N - 1);
  localparam logic [IW-1:0] K_LAST      = IW'(2 * N - 2);
  localparam logic [CW-1:0] C_LAST      = CW'(N - 1);

  conv_state_t          state_q;
  logic [IW-1:0]        k_q;
  logic [CW-1:0]        i_q;
  logic [CW-1:0]        j_q;
  logic signed [DW-1:0] a_q [N];
  logic signed [DW-1:0] b_q [N];

  logic                 busy_q;
  logic                 done_q;
  logic                 in_ready_q;
  logic                 mul_req_q;
  logic signed [DW-1:0] mul_a_q;
  logic signed [DW-1:0] mul_b_q;
  logic                 out_valid_q;
  logic signed [RW-1:0] out_data_q;
  logic [IW-1:0]        out_idx_q;
  logic                 out_last_q;

  logic [CW-1:0]        i_d;
  logic [CW-1:0]        j_d;
  logic [IW-1:0]        k_inc_s;
  logic                 in_fire_s;
  logic                 mul_fire_s;
  logic                 mul_last_s;
  logic                 out_fire_s;
  logic                 acc_clr_s;
  logic [IW-1:0]        add_idx_s;
  logic signed [RW-1:0] add_val_s;
  logic [IW-1:0]        rd_idx_s;
  logic signed [RW-1:0] rd_data_s;

  assign in_fire_s  = bus.in_valid & in_ready_q;
  assign mul_fire_s = (state_q == ST_MUL) & mul_req_q & bus.mul_ack;
  assign mul_last_s = (i_q == C_LAST) & (j_q == C_LAST);
  assign out_fire_s = (state_q == ST_DRAIN) & out_valid_q & bus.out_ready;
  assign acc_clr_s  = (state_q == ST_IDLE) & bus.start;
  assign k_inc_s    = k_q + IW'(1);
  assign add_idx_s  = IW'(i_q) + IW'(j_q);
  assign add_val_s  = {{(RW - 2 * DW){bus.mul_p[2*DW-1]}}, bus.mul_p};

  // Next product coordinates: j runs fastest, i steps when j wraps.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (j_q == C_LAST) begin
      j_d = '0;
      i_d = i_q + CW'(1);
    end else begin
      j_d = j_q + CW'(1);
    end
  end

  // Read-ahead index: in DRAIN we prefetch the result after the one on the
  // bus; on the MUL->DRAIN step the index is 0, whose sum is already final.
  always_comb begin
    rd_idx_s = '0;
    if (state_q == ST_DRAIN) begin
      rd_idx_s = k_inc_s;
    end else begin
      rd_idx_s = '0;
    end
  end

  conv_acc_bank #(
    .NACC (NACC),
    .RW   (RW),
    .IW   (IW)
  ) u_acc_bank (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (acc_clr_s),
    .add_en_i  (mul_fire_s),
    .add_idx_i (add_idx_s),
    .add_val_i (add_val_s),
    .rd_idx_i  (rd_idx_s),
    .rd_data_o (rd_data_s)
  );

  // Sequencer FSM with counters, sample storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      for (int e = 0; e < N; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mul_req_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_LOAD_A;
            k_q        <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end

        ST_LOAD_A: begin
          if (in_fire_s) begin
            a_q[k_q] <= bus.in_data;
            if (k_q == K_LOAD_LAST) begin
              k_q     <= '0;
              state_q <= ST_LOAD_B;
            end else begin
              k_q <= k_inc_s;
            end
          end
        end

        ST_LOAD_B: begin
          if (in_fire_s) begin
            b_q[k_q] <= bus.in_data;
            if (k_q == K_LOAD_LAST) begin
              // B[0] and A[0] are already stored (N >= 2), so the first
              // request can be presented right away.
              k_q        <= '0;
              i_q        <= '0;
              j_q        <= '0;
              state_q    <= ST_MUL;
              in_ready_q <= 1'b0;
              mul_req_q  <= 1'b1;
              mul_a_q    <= a_q[0];
              mul_b_q    <= b_q[0];
            end else begin
              k_q <= k_inc_s;
            end
          end
        end

        ST_MUL: begin
          if (mul_fire_s) begin
            if (mul_last_s) begin
              state_q     <= ST_DRAIN;
              mul_req_q   <= 1'b0;
              mul_a_q     <= '0;
              mul_b_q     <= '0;
              k_q         <= '0;
              out_valid_q <= 1'b1;
              out_idx_q   <= '0;
              out_data_q  <= rd_data_s;
              out_last_q  <= 1'b0;
            end else begin
              i_q     <= i_d;
              j_q     <= j_d;
              mul_a_q <= a_q[i_d];
              mul_b_q <= b_q[j_d];
            end
          end
        end

        ST_DRAIN: begin
          if (out_fire_s) begin
            if (k_q == K_LAST) begin
              state_q     <= ST_DONE;
              k_q         <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              k_q        <= k_inc_s;
              out_idx_q  <= k_inc_s;
              out_data_q <= rd_data_s;
              out_last_q <= (k_inc_s == K_LAST);
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          mul_req_q   <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.mul_req   = mul_req_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_sequencer
// Directed bench for conv_sequencer (N=8, DW=8, RW=20). Inputs are driven and
// outputs sampled on the falling edge; a behavioural multiplier answers
// requests with a programmable delay and optional spurious acks.
// -----------------------------------------------------------------------------
module tb_conv_sequencer;

  typedef int vec8_t [8];
  typedef int vec15_t [15];

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  conv_sequencer_if #(.DW(8), .RW(20), .IW(4)) bus ();

  conv_sequencer #(.N(8), .DW(8), .RW(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_total    = 0;
  int n_bad      = 0;
  int hs_cnt     = 0;
  int req_cycles = 0;
  int done_cnt   = 0;
  bit delay_mode = 1'b0;
  bit spur_en    = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event counters seen at the active edge.
  always @(posedge clk) begin
    if (!rst && bus.mul_req && bus.mul_ack) hs_cnt <= hs_cnt + 1;
    if (!rst && bus.mul_req) req_cycles <= req_cycles + 1;
    if (!rst && bus.done) done_cnt <= done_cnt + 1;
  end

  // Behavioural multiplier with optional latency and spurious acks.
  initial begin : mul_model
    bit pending;
    int wait_left;
    logic signed [7:0]  hold_a;
    logic signed [7:0]  hold_b;
    logic signed [15:0] prod;
    pending = 1'b0;
    wait_left = 0;
    hold_a = '0;
    hold_b = '0;
    bus.mul_ack = 1'b0;
    bus.mul_p = '0;
    forever begin
      @(negedge clk);
      if (bus.mul_req) begin
        if (!pending) begin
          pending = 1'b1;
          hold_a = bus.mul_a;
          hold_b = bus.mul_b;
          wait_left = delay_mode ? int'($urandom_range(0, 3)) : 0;
        end else begin
          chk("mul_a_stable", int'(bus.mul_a), int'(hold_a));
          chk("mul_b_stable", int'(bus.mul_b), int'(hold_b));
        end
        if (wait_left == 0) begin
          prod = $signed(bus.mul_a) * $signed(bus.mul_b);
          bus.mul_p = prod;
          bus.mul_ack = 1'b1;
          pending = 1'b0;
        end else begin
          bus.mul_ack = 1'b0;
          bus.mul_p = 16'($urandom);
          wait_left--;
        end
      end else begin
        pending = 1'b0;
        bus.mul_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mul_p = 16'($urandom);
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_done"},      int'(bus.done), 0);
    chk({tag, "_in_ready"},  int'(bus.in_ready), 0);
    chk({tag, "_mul_req"},   int'(bus.mul_req), 0);
    chk({tag, "_mul_a"},     int'(bus.mul_a), 0);
    chk({tag, "_mul_b"},     int'(bus.mul_b), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_last"},  int'(bus.out_last), 0);
    chk({tag, "_out_data"},  int'(bus.out_data), 0);
    chk({tag, "_out_idx"},   int'(bus.out_idx), 0);
  endtask

  task automatic load_vec(input vec8_t va, input vec8_t vb, input bit gaps, input string tag);
    int g;
    for (int s = 0; s < 16; s++) begin
      if (gaps && (s % 3 == 1)) begin
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      g = 0;
      while (!bus.in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) chk({tag, "_in_ready_timeout"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data = (s < 8) ? 8'(va[s]) : 8'(vb[s - 8]);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic run_conv(input vec8_t va, input vec8_t vb, input vec15_t ve,
                          input bit gaps, input bit toggle_rdy, input bit poke,
                          input string tag);
    int hs0, rq0, dn0, cnt, cyc;
    bit tog, poked, r;
    hs0 = hs_cnt;
    rq0 = req_cycles;
    dn0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_load"}, int'(bus.busy), 1);
    load_vec(va, vb, gaps, tag);
    cnt = 0;
    cyc = 0;
    tog = 1'b0;
    poked = 1'b0;
    while (cnt < 15 && cyc < 3000) begin
      if (poke && bus.mul_req && !poked) begin
        bus.start = 1'b1;
        poked = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      r = toggle_rdy ? tog : 1'b1;
      tog = !tog;
      bus.out_ready = r;
      if (bus.out_valid) begin
        chk({tag, "_idx"},  int'(bus.out_idx), cnt);
        chk({tag, "_last"}, int'(bus.out_last), (cnt == 14) ? 1 : 0);
        chk({tag, "_data"}, int'(bus.out_data), ve[cnt]);
        if (r) cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    if (cyc >= 3000) chk({tag, "_drain_timeout"}, cnt, 15);
    // Now in DONE.
    chk({tag, "_done_pulse"}, int'(bus.done), 1);
    chk({tag, "_busy_done"},  int'(bus.busy), 1);
    chk({tag, "_valid_done"}, int'(bus.out_valid), 0);
    if (poke) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_low"}, int'(bus.done), 0);
    chk({tag, "_busy_idle"}, int'(bus.busy), 0);
    @(negedge clk);
    chk({tag, "_stay_idle"}, int'(bus.busy), 0);
    chk({tag, "_in_ready_idle"}, int'(bus.in_ready), 0);
    chk({tag, "_handshakes"}, hs_cnt - hs0, 64);
    chk({tag, "_done_count"}, done_cnt - dn0, 1);
    if (!delay_mode) chk({tag, "_mul_cycles"}, req_cycles - rq0, 64);
  endtask

  task automatic abort_run(input vec8_t va, input vec8_t vb);
    int hs0, dn0, g;
    hs0 = hs_cnt;
    dn0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    load_vec(va, vb, 1'b0, "abort");
    bus.out_ready = 1'b1;
    g = 0;
    while (!((hs_cnt - hs0 == 29) && bus.mul_req) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) chk("abort_wait_timeout", hs_cnt - hs0, 29);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_valid", int'(bus.out_valid), 0);
      chk("abort_no_busy", int'(bus.busy), 0);
    end
    bus.out_ready = 1'b0;
    chk("abort_handshakes", hs_cnt - hs0, 29);
    chk("abort_no_done", done_cnt - dn0, 0);
  endtask

  // Safety net against a hung design.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec8_t  imp_a, imp_b, ext_v, alt_v, new_a, new_b;
    vec15_t imp_e, ext_e, alt_e, new_e;

    imp_a = '{1, 0, 0, 0, 0, 0, 0, 0};
    imp_b = '{1, 2, 3, 4, 5, 6, 7, 8};
    imp_e = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0};
    ext_v = '{-128, -128, -128, -128, -128, -128, -128, -128};
    ext_e = '{16384, 32768, 49152, 65536, 81920, 98304, 114688, 131072,
              114688, 98304, 81920, 65536, 49152, 32768, 16384};
    alt_v = '{1, -1, 1, -1, 1, -1, 1, -1};
    alt_e = '{1, -2, 3, -4, 5, -6, 7, -8, 7, -6, 5, -4, 3, -2, 1};
    new_a = '{2, 1, 0, 0, 0, 0, 0, 0};
    new_b = '{3, 0, 0, 0, 0, 0, 0, -1};
    new_e = '{6, 3, 0, 0, 0, 0, 0, -2, -1, 0, 0, 0, 0, 0, 0};

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run_conv(imp_a, imp_b, imp_e, 1'b0, 1'b0, 1'b0, "impulse");
    run_conv(ext_v, ext_v, ext_e, 1'b0, 1'b0, 1'b0, "extreme");

    delay_mode = 1'b1;
    spur_en = 1'b1;
    run_conv(alt_v, alt_v, alt_e, 1'b0, 1'b0, 1'b0, "latency");
    delay_mode = 1'b0;

    run_conv(imp_a, imp_b, imp_e, 1'b1, 1'b1, 1'b0, "stall");
    spur_en = 1'b0;

    run_conv(ext_v, ext_v, ext_e, 1'b0, 1'b0, 1'b1, "control");
    run_conv(ext_v, ext_v, ext_e, 1'b0, 1'b0, 1'b0, "repeat");

    abort_run(alt_v, alt_v);
    run_conv(new_a, new_b, new_e, 1'b0, 1'b0, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
